// File: rtl/mem_bank_hs.sv
// Generic RAM slave with valid/ready request and in-order response channels.
// Optional per-byte parity storage and error injection: MEM_BANK_PARITY_EN.
module mem_bank_hs #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LAT     = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wr_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [WIDTH-1:0]      req_wdata_i,
    input  logic [WIDTH/8-1:0]    req_be_i,
`ifdef MEM_BANK_PARITY_EN
    input  logic                  err_inj_i,
`endif
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  init_done_o
);

    localparam int NB = WIDTH / 8;
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [WIDTH-1:0]        mem [DEPTH];
`ifdef MEM_BANK_PARITY_EN
    logic [NB-1:0]           par [DEPTH];
`endif

    logic                    accept;
    logic                    pop;
    logic                    push;
    logic                    oor;
    logic                    par_err;
    logic [WIDTH-1:0]        rd_data;
    logic [CW-1:0]           cnt;

    logic [RD_LAT-1:0]       pv;
    logic [RD_LAT-1:0]       pe;
    logic [WIDTH-1:0]        pd [RD_LAT];

    logic [WIDTH-1:0]        fd [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]    fe;
    logic [PW:0]             wptr;
    logic [PW:0]             rptr;
    logic                    empty;

    assign req_ready_o = (state == RUN) && (cnt < CW'(RSP_DEPTH));
    assign accept      = req_valid_i && req_ready_o;
    assign oor         = 32'(req_addr_i) >= DEPTH;
    assign empty       = (wptr == rptr);
    assign pop         = !empty && rsp_ready_i;
    assign push        = pv[RD_LAT-1];
    assign rsp_valid_o = !empty;
    assign rsp_rdata_o = empty ? '0 : fd[rptr[PW-1:0]];
    assign rsp_err_o   = !empty && fe[rptr[PW-1:0]];

    // Array read for the request presented this cycle, plus parity check
    always_comb begin
        rd_data = '0;
        par_err = 1'b0;
        if (!oor) begin
            rd_data = mem[req_addr_i];
`ifdef MEM_BANK_PARITY_EN
            for (int b = 0; b < NB; b++) begin
                if ((^rd_data[8*b +: 8]) != par[req_addr_i][b]) begin
                    par_err = 1'b1;
                end
            end
`endif
        end
    end

    // Init sweep FSM: clear every word once after reset, then serve requests
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= INIT;
            init_cnt    <= '0;
            init_done_o <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        state       <= RUN;
                        init_done_o <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + ADDR_WIDTH'(1);
                    end
                end
                RUN: ;
                default: state <= INIT;
            endcase
        end
    end

    // Storage writes: zero fill during init, byte-enabled writes in run
    always_ff @(posedge clk_i) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
`ifdef MEM_BANK_PARITY_EN
            par[init_cnt] <= '0;
`endif
        end else if (accept && req_wr_i && !oor) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be_i[b]) begin
                    mem[req_addr_i][8*b +: 8] <= req_wdata_i[8*b +: 8];
`ifdef MEM_BANK_PARITY_EN
                    par[req_addr_i][b] <= (^req_wdata_i[8*b +: 8])
                                          ^ (err_inj_i && (b == 0));
`endif
                end
            end
        end
    end

    // Latency pipeline: response info captured at accept, delayed RD_LAT edges
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= accept;
            pe[0] <= oor || (!req_wr_i && par_err);
            pd[0] <= req_wr_i ? '0 : rd_data;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    // Response FIFO pointers and outstanding-credit counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + (PW+1)'(1);
            if (pop)  rptr <= rptr + (PW+1)'(1);
            if (accept && !pop)      cnt <= cnt + CW'(1);
            else if (!accept && pop) cnt <= cnt - CW'(1);
        end
    end

    // Response FIFO storage
    always_ff @(posedge clk_i) begin
        if (push) begin
            fd[wptr[PW-1:0]] <= pd[RD_LAT-1];
            fe[wptr[PW-1:0]] <= pe[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_mem_bank_hs.sv
// Directed bench for mem_bank_hs: u0 default build, u1 DEPTH=300 RD_LAT=3.
// Define MEM_BANK_PARITY_EN to also exercise parity storage and injection.
module tb_mem_bank_hs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rv [2];
    logic        rw [2];
    logic [8:0]  ad [2];
    logic [15:0] wd [2];
    logic [1:0]  be [2];
    logic        rr [2];
    logic        rdy [2];
    logic        vld [2];
    logic [15:0] rd [2];
    logic        er [2];
    logic        dn [2];
`ifdef MEM_BANK_PARITY_EN
    logic        inj [2];
`endif

    int nchk = 0;
    int nerr = 0;
    int acc [2];
    int lat_of [2] = '{1, 3};

    always #5 clk = ~clk;

    mem_bank_hs u0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(rv[0]), .req_ready_o(rdy[0]), .req_wr_i(rw[0]),
        .req_addr_i(ad[0]), .req_wdata_i(wd[0]), .req_be_i(be[0]),
`ifdef MEM_BANK_PARITY_EN
        .err_inj_i(inj[0]),
`endif
        .rsp_valid_o(vld[0]), .rsp_ready_i(rr[0]), .rsp_rdata_o(rd[0]),
        .rsp_err_o(er[0]), .init_done_o(dn[0])
    );

    mem_bank_hs #(.DEPTH(300), .RD_LAT(3)) u1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(rv[1]), .req_ready_o(rdy[1]), .req_wr_i(rw[1]),
        .req_addr_i(ad[1]), .req_wdata_i(wd[1]), .req_be_i(be[1]),
`ifdef MEM_BANK_PARITY_EN
        .err_inj_i(inj[1]),
`endif
        .rsp_valid_o(vld[1]), .rsp_ready_i(rr[1]), .rsp_rdata_o(rd[1]),
        .rsp_err_o(er[1]), .init_done_o(dn[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int d, input logic w, input logic [8:0] a,
                         input logic [15:0] data, input logic [1:0] b);
        int n = 0;
        rv[d] = 1'b1;
        rw[d] = w;
        ad[d] = a;
        wd[d] = data;
        be[d] = b;
        while (!rdy[d] && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk("issue_timeout", 32'(n), 0);
        @(posedge clk);
        #1;
        rv[d] = 1'b0;
        acc[d]++;
    endtask

    task automatic expect_rsp(input int d, input logic [15:0] exp_d,
                              input logic exp_e, input string tag);
        int n = 0;
        while (!vld[d] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(vld[d]), 1);
        chk({tag, "_rdata"}, 32'(rd[d]), 32'(exp_d));
        chk({tag, "_err"}, 32'(er[d]), 32'(exp_e));
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int d, input logic w, input logic [8:0] a,
                       input logic [15:0] data, input logic [1:0] b,
                       input logic [15:0] exp_d, input logic exp_e,
                       input string tag);
        int lat = 0;
        issue(d, w, a, data, b);
        while (!vld[d] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(lat_of[d]));
        expect_rsp(d, exp_d, exp_e, tag);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        int at [2] = '{0, 0};
        int bad = 0;
        while ((at[0] == 0 || at[1] == 0) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            for (int d = 0; d < 2; d++) begin
                if (dn[d] && at[d] == 0) at[d] = n;
                if (!dn[d] && rdy[d]) bad++;
            end
        end
        chk({tag, "_done512"}, 32'(at[0]), 512);
        chk({tag, "_done300"}, 32'(at[1]), 300);
        chk({tag, "_ready_low"}, 32'(bad), 0);
    endtask

    logic [8:0]  bp_addr [6] = '{9'd3, 9'd5, 9'h1FF, 9'd3, 9'd5, 9'd0};
    logic [15:0] bp_data [6] = '{16'hA534, 16'hBEEF, 16'h0,
                                 16'hA534, 16'hBEEF, 16'h0};

    initial begin
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rw[d] = 1'b0; ad[d] = '0;
            wd[d] = '0; be[d] = '0; rr[d] = 1'b1; acc[d] = 0;
`ifdef MEM_BANK_PARITY_EN
            inj[d] = 1'b0;
`endif
        end
        rv[0] = 1'b1;
        #23;
        chk("rst_ready", 32'(rdy[0]), 0);
        chk("rst_valid", 32'(vld[0]), 0);
        chk("rst_done", 32'(dn[0]), 0);
        chk("rst_rdata", 32'(rd[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init");
        chk("init_no_accept", 32'(u0.cnt), 0);
        rv[0] = 1'b0;

        txn(0, 1'b0, 9'h1FF, 16'h0, 2'b00, 16'h0, 1'b0, "rd1ff");
        txn(0, 1'b1, 9'd3, 16'hA5A5, 2'b11, 16'h0, 1'b0, "w0_full");
        txn(0, 1'b1, 9'd3, 16'h1234, 2'b01, 16'h0, 1'b0, "w0_lo");
        txn(0, 1'b0, 9'd3, 16'h0, 2'b00, 16'hA534, 1'b0, "r0_3");
        txn(0, 1'b1, 9'd3, 16'hFFFF, 2'b00, 16'h0, 1'b0, "w0_be0");
        txn(0, 1'b0, 9'd3, 16'h0, 2'b00, 16'hA534, 1'b0, "r0_be0");

        txn(1, 1'b1, 9'd3, 16'hA5A5, 2'b11, 16'h0, 1'b0, "w1_full");
        txn(1, 1'b1, 9'd3, 16'h1234, 2'b01, 16'h0, 1'b0, "w1_lo");
        txn(1, 1'b0, 9'd3, 16'h0, 2'b00, 16'hA534, 1'b0, "r1_3");

        issue(0, 1'b1, 9'd5, 16'hBEEF, 2'b11);
        issue(0, 1'b0, 9'd5, 16'h0, 2'b00);
        expect_rsp(0, 16'h0, 1'b0, "raw_w");
        expect_rsp(0, 16'hBEEF, 1'b0, "raw_r");

        rr[0] = 1'b0;
        acc[0] = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    issue(0, 1'b0, bp_addr[i], 16'h0, 2'b00);
                end
            end
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("bp_accepted", 32'(acc[0]), 4);
                chk("bp_ready", 32'(rdy[0]), 0);
                rr[0] = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    expect_rsp(0, bp_data[i], 1'b0, $sformatf("bp%0d", i));
                end
            end
        join
        repeat (5) @(posedge clk);
        #1;
        chk("bp_no_dup", 32'(vld[0]), 0);
        chk("bp_total", 32'(acc[0]), 6);

        txn(1, 1'b1, 9'd300, 16'hFFFF, 2'b11, 16'h0, 1'b1, "oor_w");
        txn(1, 1'b0, 9'd300, 16'h0, 2'b00, 16'h0, 1'b1, "oor_r");
        txn(1, 1'b0, 9'd299, 16'h0, 2'b00, 16'h0, 1'b0, "r299");

`ifdef MEM_BANK_PARITY_EN
        inj[0] = 1'b1;
        txn(0, 1'b1, 9'd7, 16'h00FF, 2'b11, 16'h0, 1'b0, "par_w_inj");
        inj[0] = 1'b0;
        txn(0, 1'b0, 9'd7, 16'h0, 2'b00, 16'h00FF, 1'b1, "par_r_bad");
        txn(0, 1'b1, 9'd7, 16'h00FF, 2'b11, 16'h0, 1'b0, "par_w_ok");
        txn(0, 1'b0, 9'd7, 16'h0, 2'b00, 16'h00FF, 1'b0, "par_r_ok");
`endif

        rr[0] = 1'b0;
        issue(0, 1'b0, 9'd3, 16'h0, 2'b00);
        issue(0, 1'b0, 9'd5, 16'h0, 2'b00);
        issue(0, 1'b0, 9'd0, 16'h0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_pending", 32'(vld[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid_drop", 32'(vld[0]), 0);
        chk("mid_done_drop", 32'(dn[0]), 0);
        chk("mid_ready_drop", 32'(rdy[0]), 0);
        rr[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (vld[0]) chk("mid_stale", 32'(vld[0]), 0);
        end
        chk("mid_no_stale", 32'(vld[0]), 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit");
        txn(0, 1'b0, 9'd3, 16'h0, 2'b00, 16'h0, 1'b0, "reinit_r3");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_bank_hs.md
Name: mem_bank_hs

Overview:
Parametrised successor to the single-port valid/ready memory. It adds:
- byte-enabled writes
- configurable read latency
- an in-order response channel with backpressure (response FIFO plus credit counter)
- out-of-range address detection
- a hardware init sweep that replaces reset-time clearing of the array

It sits between a bus-side requester and local storage as a generic RAM slave.

Parameters:
- WIDTH, 16, data width in bits; must be a multiple of 8.
- DEPTH, 512, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- RD_LAT, 1, request-accept to response-valid latency in cycles; legal range 1..4.
- RSP_DEPTH, 4, response FIFO entries; power of two, at least RD_LAT+1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_wr_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  word address.
- req_wdata_i  in  WIDTH  write data.
- req_be_i  in  WIDTH/8  byte enables; bit n covers data[8n+7:8n].
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_rdata_o  out  WIDTH  read data; 0 for write responses and errors.
- rsp_err_o  out  1  response error flag.
- init_done_o  out  1  array init complete.

Behaviour:
- Reset (rst_ni low, asynchronous) forces all outputs to 0 (req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, init_done_o) and clears FIFO, read pipeline, credit counter and state. Array contents are not reset directly.
- FSM states: INIT, RUN.
  - INIT is entered on reset release. An address counter writes 0 to words 0..DEPTH-1, one word per cycle.
  - After the write to DEPTH-1, move to RUN and set init_done_o=1; it stays 1 until the next reset.
  - req_ready_o=0 throughout INIT; requests presented during INIT are not accepted.
- Handshake: a request is accepted on any rising edge where req_valid_i && req_ready_o. Requester fields must be held stable while valid && !ready.
- Every accepted request, read or write, produces exactly one response, in acceptance order.
- Write: mem[addr] byte n is updated at the accept edge where req_be_i[n]=1; other bytes are unchanged. be=0 is legal: no update, normal response.
- Read: returns the full word at addr as of the accept edge.
- Read-after-write to the same address in back-to-back cycles returns the new data.
- Latency: for a request accepted at edge E0, with an empty FIFO, rsp_valid_o=1 immediately after edge E(RD_LAT). This holds for reads and writes alike.
- Response handshake: a response pops on a rising edge with rsp_valid_o && rsp_ready_i. rsp_rdata_o and rsp_err_o stay stable while valid && !ready.
- Credits: outstanding = accepted minus popped, counting pipeline plus FIFO entries.
  - req_ready_o = RUN && (outstanding < RSP_DEPTH), registered-free (combinational from state).
  - An accept and a pop on the same edge leave the count unchanged.
  - The FIFO can never overflow. With rsp_ready_i stuck at 0, exactly RSP_DEPTH requests are accepted.
- Out of range (addr >= DEPTH):
  - no array access, even when be != 0;
  - the response carries rsp_err_o=1 and rsp_rdata_o=0;
  - latency and ordering are unchanged.
- FIFO pointers use one extra wrap bit; full/empty derive from the pointers. Wrap-around of the pointers is seamless.
- Reset mid-operation discards all in-flight responses immediately (rsp_valid_o drops asynchronously) and re-runs INIT.

Optional Feature:
MEM_BANK_PARITY_EN
- Defined:
  - Each byte stores an extra even-parity bit, written with the byte.
  - Adds input port err_inj_i (1 bit). When err_inj_i=1 on a write accept, the stored parity of byte 0 is inverted.
  - A read that finds any byte parity mismatch returns the stored data with rsp_err_o=1.
  - The INIT sweep writes correct parity (0) for every byte.
- Undefined:
  - No parity storage and no err_inj_i port.
  - rsp_err_o is set only for out-of-range addresses.

Test Plan:
- Reset release, DEPTH=512 -> init_done_o rises exactly 512 cycles after rst_ni goes high; req_ready_o=0 until then; a read of addr 0x1FF afterwards returns 0x0000.
- Write 0xA5A5 to addr 3 with be=2'b11, then write 0x1234 with be=2'b01, then read addr 3 -> rdata 0xA534, err 0; each response is valid RD_LAT cycles after its accept (check RD_LAT=1 and RD_LAT=3).
- Hold rsp_ready_i=0 and issue 6 reads with RSP_DEPTH=4 -> exactly 4 are accepted and req_ready_o=0. Release rsp_ready_i -> 4 responses in order, then the remaining 2 are accepted; no loss or duplication.
- DEPTH=300: write 0xFFFF to addr 300, then read addr 300 -> both responses have err=1 and rdata 0. A read of addr 299 returns 0, unaffected.
- Pull rst_ni low while 3 responses are pending -> rsp_valid_o=0 within the same cycle, no stale responses after release, and INIT re-runs.
- MEM_BANK_PARITY_EN: write 0x00FF to addr 7 with err_inj_i=1, then read addr 7 -> rdata 0x00FF, err 1. Rewrite with err_inj_i=0 and read -> err 0.
